i2c_scl_gen: RTL and testbench

- Parametrised successor to the single-rate I2C clock stretcher.
- Generates the four-phase SCL and data_clk timing for an I2C master at three runtime-selectable bus speeds.
- Detects slave clock stretching and bounds stretch duration with a timeout.
- Sits between the I2C master byte/bit FSM and the open-drain SCL pad.

---
 rtl/i2c_scl_gen.sv | 148 ++++++++++++++
 tb/tb_i2c_scl_gen.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_scl_gen.sv
// Four-phase I2C SCL / data_clk generator with three runtime bus speeds,
// slave clock-stretch detection at the SCL-high window and a stretch timeout.
module i2c_scl_gen #(
  parameter int DIV_STD    = 250,
  parameter int DIV_FAST   = 63,
  parameter int DIV_FASTP  = 25,
  parameter int CBITS      = 16,
  parameter int TMO_CYCLES = 4096,
  parameter int TBITS      = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [1:0] mode,
  input  logic       scl_in,
  output logic       scl_oe,
  output logic       data_clk,
  output logic [1:0] phase,
  output logic       switch_range,
  output logic       quarter_tick,
  output logic       stretching,
  output logic       timeout,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_TIMEOUT = 2'd2
  } state_e;

  localparam logic [CBITS-1:0] DIV_STD_C   = CBITS'(DIV_STD);
  localparam logic [CBITS-1:0] DIV_FAST_C  = CBITS'(DIV_FAST);
  localparam logic [CBITS-1:0] DIV_FASTP_C = CBITS'(DIV_FASTP);
  localparam logic [TBITS-1:0] TMO_C       = TBITS'(TMO_CYCLES);

  state_e           state_q, state_d;
  logic [CBITS-1:0] cnt_q, cnt_d;
  logic [CBITS-1:0] div_q, div_d;
  logic [TBITS-1:0] tmo_q, tmo_d;
  logic [1:0]       phase_q, phase_d;
  logic             scl_oe_q, scl_oe_d;
  logic             data_clk_q, data_clk_d;
  logic             switch_range_q, switch_range_d;
  logic             quarter_tick_q, quarter_tick_d;
  logic             stretching_q, stretching_d;
  logic             timeout_q, timeout_d;
  logic [CBITS-1:0] mode_div;
  logic             run_d;

  always_comb begin
    case (mode)
      2'd1:    mode_div = DIV_FAST_C;
      2'd2:    mode_div = DIV_FASTP_C;
      default: mode_div = DIV_STD_C;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    tmo_d        = tmo_q;
    phase_d      = phase_q;
    stretching_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        div_d   = mode_div;
        cnt_d   = '0;
        phase_d = 2'd0;
        tmo_d   = '0;
        if (ena) state_d = S_RUN;
      end
      S_RUN: begin
        // The threshold is checked in a displayed stretch cycle, so it wins
        // over scl_in rising in that same cycle.
        if (stretching_q && (tmo_q == TMO_C)) begin
          state_d = S_TIMEOUT;
          cnt_d   = '0;
          phase_d = 2'd0;
        end else if ((phase_q == 2'd2) && (cnt_q == '0) && !scl_in) begin
          stretching_d = 1'b1;
          tmo_d        = tmo_q + TBITS'(1);
        end else if (cnt_q == div_q - CBITS'(1)) begin
          cnt_d   = '0;
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd1) tmo_d = '0;
          if (phase_q == 2'd3) begin
            if (!ena) state_d = S_IDLE;
            else      div_d   = mode_div;
          end
        end else begin
          cnt_d = cnt_q + CBITS'(1);
        end
      end
      S_TIMEOUT: begin
        if (!ena) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they land in registers.
    run_d          = (state_d == S_RUN);
    scl_oe_d       = run_d && !phase_d[1];
    data_clk_d     = run_d && (phase_d[1] ^ phase_d[0]);
    switch_range_d = run_d && (phase_d == 2'd2);
    quarter_tick_d = run_d && (cnt_d == div_d - CBITS'(1));
    timeout_d      = (state_d == S_TIMEOUT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      div_q          <= DIV_STD_C;
      tmo_q          <= '0;
      phase_q        <= 2'd0;
      scl_oe_q       <= 1'b0;
      data_clk_q     <= 1'b0;
      switch_range_q <= 1'b0;
      quarter_tick_q <= 1'b0;
      stretching_q   <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      div_q          <= div_d;
      tmo_q          <= tmo_d;
      phase_q        <= phase_d;
      scl_oe_q       <= scl_oe_d;
      data_clk_q     <= data_clk_d;
      switch_range_q <= switch_range_d;
      quarter_tick_q <= quarter_tick_d;
      stretching_q   <= stretching_d;
      timeout_q      <= timeout_d;
    end
  end

  assign scl_oe       = scl_oe_q;
  assign data_clk     = data_clk_q;
  assign phase        = phase_q;
  assign switch_range = switch_range_q;
  assign quarter_tick = quarter_tick_q;
  assign stretching   = stretching_q;
  assign timeout      = timeout_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Table-driven bench for i2c_scl_gen with small dividers and timeout so that
// whole periods, mode changes, stretches and timeouts fit in short runs.
module tb_i2c_scl_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ena = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       scl_in = 1'b1;
  logic       scl_oe, data_clk, switch_range, quarter_tick, stretching, timeout;
  logic [1:0] phase, dbg_state;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst_n;
    logic       ena;
    logic [1:0] mode;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  i2c_scl_gen #(
    .DIV_STD(4), .DIV_FAST(2), .DIV_FASTP(3),
    .CBITS(8), .TMO_CYCLES(8), .TBITS(4)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .scl_in(scl_in),
    .scl_oe(scl_oe), .data_clk(data_clk), .phase(phase),
    .switch_range(switch_range), .quarter_tick(quarter_tick),
    .stretching(stretching), .timeout(timeout), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Packed view: {scl_oe, data_clk, phase[1:0], switch_range, quarter_tick, stretching, timeout}
  function automatic logic [7:0] outs();
    return {scl_oe, data_clk, phase, switch_range, quarter_tick, stretching, timeout};
  endfunction

  function automatic void add(input logic r, input logic e, input logic [1:0] m, input logic [7:0] x);
    vec_t v;
    v.rst_n = r; v.ena = e; v.mode = m; v.exp = x;
    vecs.push_back(v);
  endfunction

  task automatic step(input logic r, input logic e, input logic [1:0] m, input logic s);
    @(negedge clk);
    rst = r; ena = e; mode = m; scl_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_to_ph2();
    for (int i = 0; i < 40 && phase != 2'd2; i++) step(1'b1, 1'b1, 2'd0, 1'b1);
    chk("reach_phase2", {30'd0, phase}, 32'd2);
  endtask

  task automatic measure(input logic [1:0] m, output int per);
    step(1'b0, 1'b0, m, 1'b1);
    step(1'b1, 1'b1, m, 1'b1);
    per = 1;
    for (int i = 0; i < 100 && !(quarter_tick && phase == 2'd3); i++) begin
      step(1'b1, 1'b1, m, ~scl_oe);
      per++;
    end
  endtask

  initial begin
    int per, ph2, strc, lows;
    logic sin, tmo_seen;

    // Reset then idle
    add(0,0,0,8'h00); add(1,0,0,8'h00);
    // Standard period, div 4
    add(1,1,0,8'h80); add(1,1,0,8'h80); add(1,1,0,8'h80); add(1,1,0,8'h84);
    add(1,1,0,8'hD0); add(1,1,0,8'hD0); add(1,1,0,8'hD0); add(1,1,0,8'hD4);
    add(1,1,0,8'h68); add(1,1,0,8'h68); add(1,1,0,8'h68); add(1,1,0,8'h6C);
    add(1,1,0,8'h30); add(1,1,0,8'h30); add(1,1,0,8'h30); add(1,1,0,8'h34);
    // Mode switched to fast during phase 1: this period stays 16 cycles
    add(1,1,0,8'h80); add(1,1,0,8'h80); add(1,1,0,8'h80); add(1,1,0,8'h84);
    add(1,1,1,8'hD0); add(1,1,1,8'hD0); add(1,1,1,8'hD0); add(1,1,1,8'hD4);
    add(1,1,1,8'h68); add(1,1,1,8'h68); add(1,1,1,8'h68); add(1,1,1,8'h6C);
    add(1,1,1,8'h30); add(1,1,1,8'h30); add(1,1,1,8'h30); add(1,1,1,8'h34);
    // Fast period, div 2
    add(1,1,1,8'h80); add(1,1,1,8'h84); add(1,1,1,8'hD0); add(1,1,1,8'hD4);
    add(1,1,1,8'h68); add(1,1,1,8'h6C); add(1,1,1,8'h30); add(1,1,1,8'h34);
    // ena dropped in phase 1: period completes, then IDLE, then restart in std
    add(1,1,1,8'h80); add(1,1,1,8'h84); add(1,0,1,8'hD0); add(1,0,1,8'hD4);
    add(1,0,1,8'h68); add(1,0,1,8'h6C); add(1,0,1,8'h30); add(1,0,1,8'h34);
    add(1,0,1,8'h00); add(1,0,0,8'h00);
    add(1,1,0,8'h80); add(1,1,0,8'h80); add(1,1,0,8'h80); add(1,1,0,8'h84);
    add(1,1,0,8'hD0);

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].ena, vecs[i].mode, 1'b1);
      chk($sformatf("vec%0d", i), {24'd0, outs()}, {24'd0, vecs[i].exp});
    end

    // Fast-plus and reserved mode periods
    measure(2'd2, per);
    chk("period_fastplus", per, 32'd12);
    measure(2'd3, per);
    chk("period_reserved_std", per, 32'd16);

    // Five low samples from phase 2 entry
    step(1'b0, 1'b0, 2'd0, 1'b1);
    step(1'b1, 1'b1, 2'd0, 1'b1);
    per = 1; ph2 = 0; strc = 0; lows = 0; tmo_seen = 1'b0;
    for (int i = 0; i < 60 && !(quarter_tick && phase == 2'd3); i++) begin
      sin = 1'b1;
      if (phase == 2'd2 && lows < 5) begin
        sin = 1'b0;
        lows++;
      end
      step(1'b1, 1'b1, 2'd0, sin);
      per++;
      if (phase == 2'd2) ph2++;
      if (stretching) strc++;
      if (timeout) tmo_seen = 1'b1;
    end
    chk("stretch_period", per, 32'd21);
    chk("stretch_phase2_len", ph2, 32'd9);
    chk("stretch_cycles", strc, 32'd5);
    chk("stretch_no_timeout", {31'd0, tmo_seen}, 32'd0);

    // Stuck-low SCL -> timeout after 8 stretch cycles
    step(1'b0, 1'b0, 2'd0, 1'b1);
    step(1'b1, 1'b1, 2'd0, 1'b1);
    run_to_ph2();
    strc = 0;
    for (int i = 0; i < 40 && !timeout; i++) begin
      step(1'b1, 1'b1, 2'd0, 1'b0);
      if (stretching) strc++;
    end
    chk("timeout_set", {31'd0, timeout}, 32'd1);
    chk("timeout_stretch_cycles", strc, 32'd8);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 2'd0, 1'b0);
      chk($sformatf("timeout_hold%0d", i), {24'd0, outs()}, 32'h01);
    end
    step(1'b1, 1'b0, 2'd0, 1'b0);
    chk("timeout_exit_outs", {24'd0, outs()}, 32'h00);
    chk("timeout_exit_state", {30'd0, dbg_state}, 32'd0);

    // Reset in the middle of a stretch
    step(1'b0, 1'b0, 2'd0, 1'b1);
    step(1'b1, 1'b1, 2'd0, 1'b1);
    run_to_ph2();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 2'd0, 1'b0);
    chk("midstretch_stretching", {31'd0, stretching}, 32'd1);
    step(1'b0, 1'b1, 2'd0, 1'b0);
    chk("midstretch_reset_outs", {24'd0, outs()}, 32'h00);
    chk("midstretch_reset_state", {30'd0, dbg_state}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 2'd0, 1'b0);
      chk($sformatf("post_reset_idle%0d", i), {24'd0, outs()}, 32'h00);
    end
    step(1'b1, 1'b1, 2'd0, 1'b0);
    chk("restart_phase0", {24'd0, outs()}, 32'h80);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
